ov_cam_sccb_writer: RTL and testbench
=====================================

// Module: ov_cam_sccb_writer
// PURPOSE
//  Sequences one 3-phase SCCB write (device addr, register addr, data) onto the
//  camera SIO_C/SIO_D pins. Bus timing is paced by the one-refclk-wide rising/falling
//  strobes of the SCCB clock divider. Sits between the camera register-init ROM
//  sequencer (start/busy/done handshake) and the SIO pads.
// PARAMETERS
//  DEV_ADDR    8'h42  8-bit SCCB write address of the camera (bit0 = 0)
//  SAMPLE_ACK  1      1: sample SIO_D on each 9th bit, report in nack; 0: nack forced 0
// PORTS
//  refclk     in   1  system clock; all logic on posedge
//  resetn     in   1  asynchronous, active-low reset
//  tick_rise  in   1  divider rising strobe, 1 refclk wide
//  tick_fall  in   1  divider falling strobe, 1 refclk wide
//  start      in   1  request write; sampled only in IDLE
//  reg_addr   in   8  register sub-address, latched on accept
//  reg_data   in   8  register data, latched on accept
//  sio_d_in   in   1  SIO_D pad input (phase-3 "don't care" bit)
//  busy       out  1  high from accept cycle+1 until done
//  done       out  1  one-refclk pulse at end of transaction
//  nack       out  1  OR of sampled 9th bits of last transaction; valid with done
//  sio_c      out  1  SIO_C level (open-drain emulated: 1 = release)
//  sio_d_out  out  1  SIO_D drive value
//  sio_d_oe   out  1  SIO_D output enable (0 = tri-state)
// BEHAVIOUR
//  - tick = tick_rise | tick_fall; every FSM step below occurs on a tick cycle only.
//  - Reset (async): state IDLE, sio_c=1, sio_d_out=1, sio_d_oe=1, busy=0, done=0,
//    nack=0, shift/counters 0. Reset mid-transaction aborts at once without STOP.
//  - IDLE: start=1 -> latch shift={DEV_ADDR,reg_addr,reg_data}, clear nack, busy=1
//    next cycle, go START0. A tick coincident with accept is not consumed.
//    start while busy is ignored (not queued).
//  - START0 tick: sio_d_out=0 (sio_c still 1) -> START1.
//  - START1 tick: sio_c=0 -> BIT_Q0, byte_cnt=0, bit_cnt=0.
//  - Per bit (4 ticks): Q0: bit_cnt<8 -> sio_d_oe=1, sio_d_out=shift[23], shift<<=1;
//    bit_cnt==8 -> sio_d_oe=0. Q1: sio_c=1. Q2: if bit_cnt==8 and SAMPLE_ACK,
//    nack|=sio_d_in. Q3: sio_c=0; bit_cnt==8 -> bit_cnt=0, byte_cnt++, else bit_cnt++.
//    After Q3 of byte_cnt 2 / bit 8 -> STOP0, otherwise back to Q0.
//  - MSB first; 3 bytes x 9 bits = 27 bits = 108 ticks.
//  - STOP0 tick: sio_d_oe=1, sio_d_out=0. STOP1: sio_c=1.
//  - STOP2: sio_d_out=1, done=1 (one cycle), busy=0, -> IDLE.
//  - Total: exactly 113 ticks from accept to done. start in the cycle done is high is
//    accepted (state already IDLE).
//  - sio_c and sio_d_out never change on the same tick (SCCB setup/hold).
//  - tick_rise and tick_fall both high: single tick, one step only.
// TESTING
//  1 reset, no start, 500 ticks -> sio_c=1, sio_d_out=1, sio_d_oe=1, busy=0 throughout.
//  2 start, reg_addr=8'h12, reg_data=8'h80, sio_d_in=0 -> decoded bytes 42,12,80;
//    done after exactly 113 ticks; nack=0; START/STOP edge ordering correct.
//  3 same write, sio_d_in=1 during phase-2 9th bit -> nack=1 with done; SAMPLE_ACK=0
//    build -> nack=0.
//  4 start held high continuously -> back-to-back writes, each 113 ticks; start pulses
//    during busy produce no extra transaction.
//  5 resetn low at tick 40 of a write -> outputs idle asynchronously; next start gives
//    full clean 113-tick write.
//  6 tick_rise and tick_fall asserted together for 10 cycles -> 10 steps, not 20.

Source files
------------

// File: rtl/ov_cam_sccb_writer_if.sv
// Handshake and SIO pad bundle for the SCCB writer.
// master = ROM sequencer plus pad side (drives start/data and the pad input),
// slave  = the writer itself.
interface ov_cam_sccb_writer_if;
  logic       start;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       busy;
  logic       done;
  logic       nack;
  logic       sio_c;
  logic       sio_d_out;
  logic       sio_d_oe;
  logic       sio_d_in;

  modport master (
    output start, reg_addr, reg_data, sio_d_in,
    input  busy, done, nack, sio_c, sio_d_out, sio_d_oe
  );

  modport slave (
    input  start, reg_addr, reg_data, sio_d_in,
    output busy, done, nack, sio_c, sio_d_out, sio_d_oe
  );
endinterface

// File: rtl/ov_cam_sccb_writer.sv
// One 3-phase SCCB write (device addr, register addr, data), paced by the
// divider strobes. Each bit takes four ticks: drive SIO_D, raise SIO_C,
// sample (9th bit only), lower SIO_C, so SIO_C and SIO_D never move together.
module ov_cam_sccb_writer #(
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter bit         SAMPLE_ACK = 1'b1
) (
  input  logic                    refclk,
  input  logic                    resetn,
  input  logic                    tick_rise,
  input  logic                    tick_fall,
  ov_cam_sccb_writer_if.slave     bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START0 = 4'd1;
  localparam logic [3:0] S_START1 = 4'd2;
  localparam logic [3:0] S_Q0     = 4'd3;
  localparam logic [3:0] S_Q1     = 4'd4;
  localparam logic [3:0] S_Q2     = 4'd5;
  localparam logic [3:0] S_Q3     = 4'd6;
  localparam logic [3:0] S_STOP0  = 4'd7;
  localparam logic [3:0] S_STOP1  = 4'd8;
  localparam logic [3:0] S_STOP2  = 4'd9;

  logic [3:0]  state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        sio_c_q, sio_c_d;
  logic        sio_d_out_q, sio_d_out_d;
  logic        sio_d_oe_q, sio_d_oe_d;

  // Coincident rise/fall strobes collapse into a single step.
  logic tick;
  assign tick = tick_rise | tick_fall;

  // Next-state logic: every bus step is gated by tick; accept is not.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    nack_d      = nack_q;
    sio_c_d     = sio_c_q;
    sio_d_out_d = sio_d_out_q;
    sio_d_oe_d  = sio_d_oe_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        shift_d = {DEV_ADDR, bus.reg_addr, bus.reg_data};
        nack_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = S_START0;
      end
      S_START0: if (tick) begin
        sio_d_out_d = 1'b0;
        state_d     = S_START1;
      end
      S_START1: if (tick) begin
        sio_c_d    = 1'b0;
        bit_cnt_d  = 4'd0;
        byte_cnt_d = 2'd0;
        state_d    = S_Q0;
      end
      S_Q0: if (tick) begin
        if (bit_cnt_q == 4'd8) begin
          sio_d_oe_d = 1'b0;
        end else begin
          sio_d_oe_d  = 1'b1;
          sio_d_out_d = shift_q[23];
          shift_d     = {shift_q[22:0], 1'b0};
        end
        state_d = S_Q1;
      end
      S_Q1: if (tick) begin
        sio_c_d = 1'b1;
        state_d = S_Q2;
      end
      S_Q2: if (tick) begin
        if (SAMPLE_ACK && bit_cnt_q == 4'd8) nack_d = nack_q | bus.sio_d_in;
        state_d = S_Q3;
      end
      S_Q3: if (tick) begin
        sio_c_d = 1'b0;
        state_d = S_Q0;
        if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = 4'd0;
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = 2'd0;
            state_d    = S_STOP0;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_STOP0: if (tick) begin
        sio_d_oe_d  = 1'b1;
        sio_d_out_d = 1'b0;
        state_d     = S_STOP1;
      end
      S_STOP1: if (tick) begin
        sio_c_d = 1'b1;
        state_d = S_STOP2;
      end
      S_STOP2: if (tick) begin
        sio_d_out_d = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops the bus to idle at once, no STOP sent.
  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      sio_c_q     <= 1'b1;
      sio_d_out_q <= 1'b1;
      sio_d_oe_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
      sio_c_q     <= sio_c_d;
      sio_d_out_q <= sio_d_out_d;
      sio_d_oe_q  <= sio_d_oe_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.nack      = nack_q;
  assign bus.sio_c     = sio_c_q;
  assign bus.sio_d_out = sio_d_out_q;
  assign bus.sio_d_oe  = sio_d_oe_q;

endmodule

// File: tb/tb_ov_cam_sccb_writer.sv
// Scoreboard bench for ov_cam_sccb_writer: stimulus pushes expected writes,
// a negedge monitor decodes the SIO pins and checks each transaction at done.
module tb_ov_cam_sccb_writer;
  logic refclk = 1'b0;
  logic resetn;
  logic tick_rise, tick_fall;

  ov_cam_sccb_writer_if bif ();
  ov_cam_sccb_writer_if bif0 ();

  ov_cam_sccb_writer #(.DEV_ADDR(8'h42), .SAMPLE_ACK(1'b1)) u_dut (
    .refclk(refclk), .resetn(resetn), .tick_rise(tick_rise), .tick_fall(tick_fall), .bus(bif));
  ov_cam_sccb_writer #(.DEV_ADDR(8'h42), .SAMPLE_ACK(1'b0)) u_dut0 (
    .refclk(refclk), .resetn(resetn), .tick_rise(tick_rise), .tick_fall(tick_fall), .bus(bif0));

  always #5 refclk = ~refclk;

  typedef struct { logic [7:0] dev; logic [7:0] ra; logic [7:0] rd; logic nack; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, tick_cnt = 0, rise_cnt = 0;
  int ack_sel = -1;
  int both_req = 0;
  logic [26:0] cap;
  logic saw_start, saw_stop, edge_bad;
  logic prev_c, prev_d, prev_oe;

  // Slave ACK emulation: pull SIO_D high during the 9th bit of byte ack_sel.
  assign bif.sio_d_in = (ack_sel >= 0) && !bif.sio_d_oe &&
                        ((rise_cnt == 9*ack_sel + 8) || (rise_cnt == 9*ack_sel + 9));
  assign bif0.start    = bif.start;
  assign bif0.reg_addr = bif.reg_addr;
  assign bif0.reg_data = bif.reg_data;
  assign bif0.sio_d_in = bif.sio_d_in;

  // Divider model: rise/fall strobes alternating every 2 cycles, optional overlap burst.
  initial begin
    int tc = 0, both_left = 0, last_req = 0;
    tick_rise = 1'b0; tick_fall = 1'b0;
    forever begin
      @(posedge refclk); #1;
      if (both_req != last_req) begin last_req = both_req; both_left = 10; end
      if (both_left > 0) begin
        tick_rise = 1'b1; tick_fall = 1'b1; both_left--;
      end else begin
        tick_rise = (tc == 0); tick_fall = (tc == 2);
      end
      tc = (tc + 1) % 4;
    end
  end

  // Monitor: decode bus, count ticks while busy, score each done.
  initial begin
    exp_t e;
    prev_c = 1'b1; prev_d = 1'b1; prev_oe = 1'b1;
    saw_start = 1'b0; saw_stop = 1'b0; edge_bad = 1'b0; cap = '0;
    forever begin
      @(negedge refclk);
      if (!resetn) begin
        tick_cnt = 0; rise_cnt = 0; saw_start = 1'b0; saw_stop = 1'b0; edge_bad = 1'b0;
        prev_c = 1'b1; prev_d = 1'b1; prev_oe = 1'b1;
      end else begin
        if (bif.busy && (tick_rise || tick_fall)) tick_cnt++;
        if (bif.sio_c && !prev_c) begin
          if (rise_cnt < 27) cap[26-rise_cnt] = bif.sio_d_out;
          rise_cnt++;
        end
        if (bif.sio_d_oe && prev_c && bif.sio_c && prev_d && !bif.sio_d_out && rise_cnt == 0)
          saw_start = 1'b1;
        if (bif.sio_d_oe && prev_c && bif.sio_c && !prev_d && bif.sio_d_out && rise_cnt == 28)
          saw_stop = 1'b1;
        if (bif.sio_d_oe && prev_oe && (bif.sio_c != prev_c) && (bif.sio_d_out != prev_d))
          edge_bad = 1'b1;
        if (bif0.done) begin
          checks++;
          if (bif0.nack !== 1'b0) begin
            errors++; $display("FAIL nack_noack_build: got %b want 0", bif0.nack);
          end
        end
        if (bif.done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done with no pending write");
          end else begin
            e = exp_q.pop_front();
            checks++;
            if ({cap[26:19], cap[17:10], cap[8:1]} !== {e.dev, e.ra, e.rd}) begin
              errors++;
              $display("FAIL bytes: got %h %h %h want %h %h %h",
                       cap[26:19], cap[17:10], cap[8:1], e.dev, e.ra, e.rd);
            end
            checks++;
            if (bif.nack !== e.nack) begin
              errors++; $display("FAIL nack: got %b want %b", bif.nack, e.nack);
            end
            checks++;
            if (tick_cnt != 113) begin
              errors++; $display("FAIL tick_count: got %0d want 113", tick_cnt);
            end
            checks++;
            if (!(saw_start && saw_stop && !edge_bad && rise_cnt == 28)) begin
              errors++;
              $display("FAIL framing: start=%b stop=%b edge_bad=%b rises=%0d want 1 1 0 28",
                       saw_start, saw_stop, edge_bad, rise_cnt);
            end
          end
          tick_cnt = 0; rise_cnt = 0; saw_start = 1'b0; saw_stop = 1'b0; edge_bad = 1'b0;
        end
        prev_c = bif.sio_c; prev_d = bif.sio_d_out; prev_oe = bif.sio_d_oe;
      end
    end
  end

  task automatic push_exp(input logic [7:0] ra, input logic [7:0] rd, input logic nk);
    exp_t e;
    e.dev = 8'h42; e.ra = ra; e.rd = rd; e.nack = nk;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] ra, input logic [7:0] rd, input logic nk);
    @(posedge refclk); #1;
    bif.start = 1'b1; bif.reg_addr = ra; bif.reg_data = rd;
    push_exp(ra, rd, nk);
    @(posedge refclk); #1;
    bif.start = 1'b0;
    checks++;
    if (bif.busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_accept: got %b want 1", bif.busy);
    end
    bif.reg_addr = 8'hFF; bif.reg_data = 8'hFF;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(negedge refclk); n++; end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d dones want %0d", done_cnt, target);
    end
  endtask

  initial begin
    int tk, n;
    logic idle_ok;
    resetn = 1'b0; bif.start = 1'b0; bif.reg_addr = 8'h00; bif.reg_data = 8'h00;
    repeat (3) @(posedge refclk);
    #2;
    checks++;
    if ({bif.sio_c, bif.sio_d_out, bif.sio_d_oe, bif.busy, bif.done, bif.nack} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_state: got %b want 111000",
               {bif.sio_c, bif.sio_d_out, bif.sio_d_oe, bif.busy, bif.done, bif.nack});
    end
    @(posedge refclk); #1 resetn = 1'b1;

    // 500 idle ticks
    tk = 0; idle_ok = 1'b1;
    while (tk < 500) begin
      @(negedge refclk);
      if (tick_rise || tick_fall) tk++;
      if ({bif.sio_c, bif.sio_d_out, bif.sio_d_oe, bif.busy} !== 4'b1110) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin errors++; $display("FAIL idle_levels: got disturbed want 1110 throughout"); end

    // basic write, ACK low
    issue(8'h12, 8'h80, 1'b0); wait_done(1);
    // NACK on register-address byte, then on data byte
    ack_sel = 1; issue(8'h12, 8'h80, 1'b1); wait_done(2);
    ack_sel = 2; issue(8'hA5, 8'h3C, 1'b1); wait_done(3);
    ack_sel = -1;

    // start held high: three back-to-back writes, then stray pulses while busy
    push_exp(8'h0A, 8'h55, 1'b0); push_exp(8'h0A, 8'h55, 1'b0); push_exp(8'h0A, 8'h55, 1'b0);
    @(posedge refclk); #1;
    bif.start = 1'b1; bif.reg_addr = 8'h0A; bif.reg_data = 8'h55;
    wait_done(5);
    @(posedge refclk); #1 bif.start = 1'b0;
    repeat (3) begin
      repeat (20) @(posedge refclk);
      #1 bif.start = 1'b1;
      @(posedge refclk); #1 bif.start = 1'b0;
    end
    wait_done(6);
    repeat (600) @(posedge refclk);
    checks++;
    if (done_cnt != 6) begin errors++; $display("FAIL no_extra_write: got %0d dones want 6", done_cnt); end

    // reset at tick 40 of a write
    issue(8'h33, 8'h44, 1'b0);
    n = 0;
    while (tick_cnt < 40 && n < 1000) begin @(negedge refclk); n++; end
    checks++;
    if (tick_cnt < 40) begin errors++; $display("FAIL tick40_timeout: got %0d want 40", tick_cnt); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({bif.sio_c, bif.sio_d_out, bif.sio_d_oe, bif.busy, bif.done} !== 5'b11100) begin
      errors++;
      $display("FAIL async_abort: got %b want 11100",
               {bif.sio_c, bif.sio_d_out, bif.sio_d_oe, bif.busy, bif.done});
    end
    exp_q.delete();
    repeat (2) @(posedge refclk);
    #1 resetn = 1'b1;
    issue(8'h6B, 8'h01, 1'b0); wait_done(7);

    // overlapping strobes for 10 cycles count as 10 steps
    issue(8'h77, 8'h88, 1'b0);
    both_req = both_req + 1;
    wait_done(8);

    repeat (10) @(posedge refclk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drained: got %0d left want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
